autorange_controller: RTL and testbench

//  Measurement scheduler above the dual-slope conversion FSM. On request, fires conversions, reads the

---
 rtl/autorange_controller.sv | 189 ++++++++++++++++++
 tb/tb_autorange_controller.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/autorange_controller.sv
// autorange_controller: steps the AFE range until the dual-slope count lands in window, then hands off one result.
// Define AUTORANGE_AVG_EN to average 2^AVG_LOG2 in-window conversions per result.
module autorange_controller #(
  parameter logic [15:0] UPPER_THRESH   = 16'hF000,
  parameter logic [15:0] LOWER_THRESH   = 16'h0800,
  parameter logic [3:0]  MAX_RETRIES    = 4'd3,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'hFFFFF,
  parameter logic [2:0]  INIT_RANGE     = 3'd7
`ifdef AUTORANGE_AVG_EN
  , parameter int unsigned AVG_LOG2     = 2
`endif
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        conv_done_i,
  input  logic [15:0] conv_count_i,
  input  logic        conv_sign_i,
  input  logic        conv_range_err_i,
  output logic        conv_start_o,
  output logic [2:0]  conv_range_o,
  output logic        busy_o,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic [15:0] result_count_o,
  output logic        result_sign_o,
  output logic [2:0]  result_range_o,
  output logic        overrange_o,
  output logic        fault_o
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_EVAL, S_OUTPUT} state_e;
  state_e      state_q, state_d;
  logic [2:0]  range_q, range_d;
  logic [3:0]  retries_q, retries_d;
  logic [19:0] tmo_q, tmo_d;
  logic [15:0] count_q, count_d;
  logic        sign_q, sign_d;
  logic [15:0] res_count_q, res_count_d;
  logic        res_sign_q, res_sign_d;
  logic [2:0]  res_range_q, res_range_d;
  logic        ovr_q, ovr_d;
  logic        fault_q, fault_d;
  logic        up, dn, can, step_up, step_dn;
`ifdef AUTORANGE_AVG_EN
  localparam logic [AVG_LOG2:0] N_LAST = (AVG_LOG2+1)'((1 << AVG_LOG2) - 1);
  logic [15+AVG_LOG2:0] acc_q, acc_d, acc_sum, avg;
  logic [AVG_LOG2:0]    n_q, n_d;
  logic                 err_q, err_d;
  assign acc_sum = acc_q + {{AVG_LOG2{1'b0}}, count_q};
  assign avg     = acc_sum >> AVG_LOG2;
`endif
  assign up      = count_q > UPPER_THRESH;
  assign dn      = count_q < LOWER_THRESH;
  assign can     = retries_q < MAX_RETRIES;
  assign step_up = up && range_q != 3'd7 && can;
  assign step_dn = dn && range_q != 3'd0 && can;
  assign conv_start_o   = state_q == S_START;
  assign busy_o         = state_q != S_IDLE;
  assign result_valid_o = state_q == S_OUTPUT;
  assign conv_range_o   = range_q;
  assign result_count_o = res_count_q;
  assign result_sign_o  = res_sign_q;
  assign result_range_o = res_range_q;
  assign overrange_o    = ovr_q;
  assign fault_o        = fault_q;
  always_comb begin
    state_d     = state_q;
    range_d     = range_q;
    retries_d   = retries_q;
    tmo_d       = tmo_q;
    count_d     = count_q;
    sign_d      = sign_q;
    res_count_d = res_count_q;
    res_sign_d  = res_sign_q;
    res_range_d = res_range_q;
    ovr_d       = ovr_q;
    fault_d     = fault_q;
`ifdef AUTORANGE_AVG_EN
    acc_d       = acc_q;
    n_d         = n_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d   = S_START;
        retries_d = '0;
`ifdef AUTORANGE_AVG_EN
        acc_d     = '0;
        n_d       = '0;
`endif
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + 20'd1;
        if (conv_range_err_i || conv_done_i) begin
          count_d = conv_range_err_i ? 16'hFFFF : conv_count_i;
          sign_d  = conv_sign_i;
          state_d = S_EVAL;
`ifdef AUTORANGE_AVG_EN
          err_d   = conv_range_err_i;
`endif
        end else if (tmo_q == TIMEOUT_CYCLES - 20'd1) begin
          state_d     = S_OUTPUT;
          res_count_d = '0;
          res_sign_d  = 1'b0;
          res_range_d = range_q;
          ovr_d       = 1'b0;
          fault_d     = 1'b1;
        end
      end
      S_EVAL: begin
        res_sign_d  = sign_q;
        res_range_d = range_q;
        fault_d     = 1'b0;
        if (step_up || step_dn) begin
          range_d   = step_up ? range_q + 3'd1 : range_q - 3'd1;
          retries_d = retries_q + 4'd1;
          state_d   = S_START;
`ifdef AUTORANGE_AVG_EN
          acc_d     = '0;
          n_d       = '0;
        end else if (err_q) begin
          acc_d       = '0;
          n_d         = '0;
          state_d     = S_OUTPUT;
          res_count_d = 16'hFFFF;
          ovr_d       = 1'b1;
        end else if (n_q == N_LAST) begin
          state_d     = S_OUTPUT;
          res_count_d = avg[15:0];
          ovr_d       = avg[15:0] > UPPER_THRESH;
        end else begin
          acc_d   = acc_sum;
          n_d     = n_q + 1'b1;
          state_d = S_START;
        end
`else
        end else begin
          state_d     = S_OUTPUT;
          res_count_d = count_q;
          ovr_d       = up;
        end
`endif
      end
      S_OUTPUT: state_d = result_ready_i ? S_IDLE : S_OUTPUT;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      range_q     <= INIT_RANGE;
      retries_q   <= '0;
      tmo_q       <= '0;
      count_q     <= '0;
      sign_q      <= 1'b0;
      res_count_q <= '0;
      res_sign_q  <= 1'b0;
      res_range_q <= '0;
      ovr_q       <= 1'b0;
      fault_q     <= 1'b0;
`ifdef AUTORANGE_AVG_EN
      acc_q       <= '0;
      n_q         <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      range_q     <= range_d;
      retries_q   <= retries_d;
      tmo_q       <= tmo_d;
      count_q     <= count_d;
      sign_q      <= sign_d;
      res_count_q <= res_count_d;
      res_sign_q  <= res_sign_d;
      res_range_q <= res_range_d;
      ovr_q       <= ovr_d;
      fault_q     <= fault_d;
`ifdef AUTORANGE_AVG_EN
      acc_q       <= acc_d;
      n_q         <= n_d;
      err_q       <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_autorange_controller.sv
// tb_autorange_controller: directed measurements with a converter model; results and per-conversion ranges checked from queues.
module tb_autorange_controller;
  logic        clk_i = 1'b0, rst_n_i = 1'b0, start_i = 1'b0;
  logic        conv_done_i = 1'b0, conv_sign_i = 1'b0, conv_range_err_i = 1'b0, result_ready_i = 1'b1;
  logic [15:0] conv_count_i = '0;
  logic        conv_start_o, busy_o, result_valid_o, result_sign_o, overrange_o, fault_o;
  logic [2:0]  conv_range_o, result_range_o;
  logic [15:0] result_count_o;
  typedef struct {logic [15:0] c; logic s; int mode;} conv_t;
  typedef struct {logic [15:0] c; logic s; logic [2:0] r; logic o; logic f;} res_t;
  conv_t      cv_q[$];
  res_t       exp_q[$];
  logic [2:0] rng_q[$];
  int tests = 0, fails = 0;
  always #5 clk_i = ~clk_i;
  autorange_controller #(.TIMEOUT_CYCLES(20'd16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .conv_done_i(conv_done_i),
    .conv_count_i(conv_count_i), .conv_sign_i(conv_sign_i), .conv_range_err_i(conv_range_err_i),
    .conv_start_o(conv_start_o), .conv_range_o(conv_range_o), .busy_o(busy_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_count_o(result_count_o),
    .result_sign_o(result_sign_o), .result_range_o(result_range_o), .overrange_o(overrange_o),
    .fault_o(fault_o)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic conv(input logic [15:0] c, input logic s, input int mode, input logic [2:0] r);
    cv_q.push_back('{c, s, mode});
    rng_q.push_back(r);
  endtask
  task automatic expect_res(input logic [15:0] c, input logic s, input logic [2:0] r, input logic o, input logic f);
    exp_q.push_back('{c, s, r, o, f});
  endtask
  task automatic kick();
    @(negedge clk_i) start_i = 1'b1;
    @(negedge clk_i) start_i = 1'b0;
  endtask
  task automatic finish_meas(input string n);
    for (int i = 0; i < 300 && busy_o; i++) @(negedge clk_i);
    chk({n, " idle"}, 32'(busy_o), 0);
    chk({n, " pending convs"}, rng_q.size(), 0);
    chk({n, " pending results"}, exp_q.size(), 0);
  endtask
  always @(negedge clk_i) begin : mon
    res_t e;
    #1;
    if (rst_n_i && conv_start_o) begin
      if (rng_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected conv_start: range %0d", conv_range_o);
      end else chk("conv range", 32'(conv_range_o), 32'(rng_q.pop_front()));
    end
    if (rst_n_i && result_valid_o && result_ready_i) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected result: count %0h", result_count_o);
      end else begin
        e = exp_q.pop_front();
        chk("result count", 32'(result_count_o), 32'(e.c));
        chk("result sign", 32'(result_sign_o), 32'(e.s));
        chk("result range", 32'(result_range_o), 32'(e.r));
        chk("overrange", 32'(overrange_o), 32'(e.o));
        chk("fault", 32'(fault_o), 32'(e.f));
      end
    end
  end
  initial begin : converter
    conv_t c;
    forever begin
      @(negedge clk_i);
      #1;
      if (rst_n_i && conv_start_o && cv_q.size() > 0) begin
        c = cv_q.pop_front();
        if (c.mode != 2) begin
          repeat (2) @(negedge clk_i);
          conv_count_i = c.c; conv_sign_i = c.s; conv_done_i = 1'b1; conv_range_err_i = (c.mode == 1);
          @(negedge clk_i);
          conv_done_i = 1'b0; conv_range_err_i = 1'b0;
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat;
    repeat (2) @(negedge clk_i);
    chk("reset range", 32'(conv_range_o), 7);
    chk("reset busy", 32'(busy_o), 0);
    chk("reset valid", 32'(result_valid_o), 0);
    chk("reset conv_start", 32'(conv_start_o), 0);
    chk("reset count", 32'(result_count_o), 0);
    chk("reset result range", 32'(result_range_o), 0);
    chk("reset flags", {30'd0, overrange_o, fault_o}, 0);
    rst_n_i = 1'b1;
    conv(16'h0100, 0, 0, 7); conv(16'h0100, 0, 0, 6); conv(16'h0100, 0, 0, 5); conv(16'h0100, 1, 0, 4);
    expect_res(16'h0100, 1, 4, 0, 0); kick(); finish_meas("down 7->4");
    conv(16'h0100, 0, 0, 4); conv(16'h4000, 0, 0, 3);
    expect_res(16'h4000, 0, 3, 0, 0); kick(); finish_meas("down 4->3");
    conv(16'h4000, 1, 0, 3);
    expect_res(16'h4000, 1, 3, 0, 0); kick(); finish_meas("in window r3");
    conv(16'h0100, 0, 0, 3); conv(16'h0100, 0, 0, 2); conv(16'h0100, 0, 0, 1); conv(16'h0100, 0, 0, 0);
    expect_res(16'h0100, 0, 0, 0, 0); kick(); finish_meas("down 3->0");
    conv(16'h0100, 1, 0, 0);
    expect_res(16'h0100, 1, 0, 0, 0); kick(); finish_meas("floor r0");
    conv(16'hFFF0, 0, 0, 0); conv(16'hFFF0, 0, 0, 1); conv(16'hFFF0, 0, 0, 2); conv(16'hFFF0, 1, 0, 3);
    expect_res(16'hFFF0, 1, 3, 1, 0); kick(); finish_meas("retries exhausted");
    conv(16'hF001, 0, 0, 3); conv(16'hF001, 0, 0, 4); conv(16'h4000, 0, 0, 5);
    expect_res(16'h4000, 0, 5, 0, 0); kick(); finish_meas("up 3->5");
    conv(16'hFFF0, 0, 0, 5); conv(16'hFFF0, 0, 0, 6); conv(16'h4000, 1, 0, 7);
    expect_res(16'h4000, 1, 7, 0, 0); kick(); finish_meas("up 5->7");
    conv(16'hFFF0, 0, 0, 7);
    expect_res(16'hFFF0, 0, 7, 1, 0); kick(); finish_meas("ceiling r7");
    conv(16'hF000, 1, 0, 7);
    expect_res(16'hF000, 1, 7, 0, 0); kick(); finish_meas("upper equal");
    conv(16'h0800, 0, 0, 7);
    expect_res(16'h0800, 0, 7, 0, 0); kick(); finish_meas("lower equal");
    conv(16'h4000, 0, 1, 7);
    expect_res(16'hFFFF, 0, 7, 1, 0); kick(); finish_meas("range err");
    conv(16'h1234, 0, 2, 7);
    expect_res(16'h0000, 0, 7, 0, 1); kick();
    lat = 0;
    while (!result_valid_o && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    chk("timeout latency", lat, 17);
    finish_meas("timeout");
    chk("range after timeout", 32'(conv_range_o), 7);
    conv(16'h0100, 0, 0, 7); conv(16'h4000, 1, 0, 6);
    expect_res(16'h4000, 1, 6, 0, 0);
    result_ready_i = 1'b0;
    kick();
    for (int i = 0; i < 50 && !result_valid_o; i++) @(negedge clk_i);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      start_i = i[0];
      chk("held valid", 32'(result_valid_o), 1);
      chk("held count", 32'(result_count_o), 32'h4000);
      chk("held range", 32'(result_range_o), 6);
    end
    start_i = 1'b0;
    @(negedge clk_i) result_ready_i = 1'b1;
    finish_meas("held result");
    conv(16'h0000, 0, 2, 6);
    kick();
    repeat (4) @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    chk("async reset busy", 32'(busy_o), 0);
    chk("async reset range", 32'(conv_range_o), 7);
    chk("async reset valid", 32'(result_valid_o), 0);
    @(negedge clk_i) rst_n_i = 1'b1;
    conv(16'h4000, 1, 0, 7);
    expect_res(16'h4000, 1, 7, 0, 0); kick(); finish_meas("after reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
